bus_interface_unit: RTL and testbench
=====================================

# bus_interface_unit

Memory-side counterpart to the control unit's bus request lines. It accepts address-latch, bus-read and bus-write strobes issued by the X-group microcode. It runs a four-state external memory cycle with wait-state support and returns read data to the internal 8-bit data bus. It sits between the CPU datapath and the system memory map and raises a stall so the control unit freezes its cycle step while a transfer is outstanding.

## Interface
Parameters:
- TIMEOUT_MAX, 255: wait-state cycles allowed in T3 before the transfer is aborted; range 1..255.

Ports:
- i_Clk  input  1  system clock; all state updates on rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Address_Out  input  1  latch i_Addr16 into the memory address register (MAR).
- i_Bus_In  input  1  request memory read into the internal bus.
- i_Bus_Out  input  1  request memory write from the internal bus.
- i_Addr16  input  16  internal 16-bit address bus.
- i_Data8  input  8  internal 8-bit data bus, used as write data.
- o_Data8  output  8  read data returned to the internal bus.
- o_Data_Valid  output  1  one-cycle pulse; o_Data8 holds new read data.
- o_Done  output  1  one-cycle pulse at completion of any transfer.
- o_Stall  output  1  control unit must hold i_Cycle_Step.
- o_Error  output  1  sticky; set on a request conflict or timeout.
- o_Mem_Addr  output  16  external address.
- o_Mem_RD  output  1  external read strobe.
- o_Mem_WR  output  1  external write strobe.
- o_Mem_Data_Out  output  8  external write data.
- i_Mem_Data_In  input  8  external read data.
- i_Mem_Ready  input  1  external ready; low inserts wait states.

## Operation
- States: IDLE, T1, T2, T3, T4.
- MAR: loaded from i_Addr16 on any cycle with i_Address_Out high, including while busy. A transfer uses the MAR value captured at acceptance. If i_Address_Out and a request arrive in the same cycle, the transfer uses i_Addr16 (bypass).
- IDLE: i_Bus_In or i_Bus_Out high starts a transfer. Direction and address are captured. For a write, i_Data8 is captured into the write-data register. The FSM moves to T1.
- Conflict: if i_Bus_In and i_Bus_Out are both high, the write proceeds, the read is dropped, and o_Error is set.
- T1: o_Mem_Addr is driven; both strobes are low. The FSM moves to T2.
- T2: o_Mem_RD or o_Mem_WR is high and o_Mem_Data_Out is driven on writes. The FSM moves to T3.
- T3: the strobe is held.
  - i_Mem_Ready high: on reads, i_Mem_Data_In is captured into o_Data8; the FSM moves to T4.
  - i_Mem_Ready low: the wait counter increments. When the counter equals TIMEOUT_MAX, o_Error is set, no data is captured, and the FSM moves to T4.
- T4: both strobes are low. o_Done pulses. o_Data_Valid pulses only on a successful read. The FSM returns to IDLE.
- Requests arriving while not in IDLE are ignored. The control unit is stalled and must not issue them.
- o_Data8 holds its last value between reads.
- o_Error clears only on reset.

## Timing
- Reset values:
  - State IDLE; MAR 16'h0000; write-data register 8'h00.
  - o_Data8 8'h00; o_Mem_Addr 16'h0000; o_Mem_Data_Out 8'h00.
  - All 1-bit outputs 0; wait counter 0.
- Reset asserted mid-transfer returns the FSM to IDLE on the next edge. Strobes drop in that same cycle and no o_Done is produced.
- o_Stall is combinational: high when a request is seen in IDLE, and throughout T1–T3. It is low in T4 so the control unit advances in the same cycle as o_Done.
- Latency from request to o_Done with zero waits is 4 cycles (T1, T2, T3, T4). Each cycle of i_Mem_Ready low in T3 adds 1.
- Back-to-back transfers: a request presented in the cycle after T4 is accepted. The minimum period is therefore 5 cycles per transfer.
- Strobes are registered, one-hot (never both high), and glitch-free. Address and write data stay stable from T1 through T4.
- Wait counter: 8-bit; it saturates and does not wrap, and it resets on every new transfer.

## Structure
- Shared CPU package:
  - state encoding enum (IDLE, T1, T2, T3, T4);
  - constant T_STATES = 4;
  - the 16-bit address and 8-bit data width constants used by the other control-unit blocks.
- One sub-module, wait_timer: 8-bit saturating counter with clear, enable, and a terminal-count compare against TIMEOUT_MAX.
- The FSM, MAR, and data registers live in the top module.

## Test plan
- Read, zero waits: i_Address_Out with i_Addr16 = 16'hC000, then i_Bus_In, with memory returning 8'h5A → o_Mem_RD high in T2–T3; o_Data8 = 8'h5A; o_Data_Valid and o_Done pulse 4 cycles after the request.
- Write, 3 wait states: MAR = 16'hFF80, i_Data8 = 8'hA5, i_Bus_Out, i_Mem_Ready low for 3 cycles → o_Mem_WR high for 5 cycles; o_Mem_Data_Out = 8'hA5 throughout; o_Done at cycle 7; no o_Data_Valid.
- Same-cycle bypass: i_Address_Out with i_Addr16 = 16'h1234 together with i_Bus_In, while MAR holds 16'h0000 → o_Mem_Addr = 16'h1234.
- Conflict: i_Bus_In and i_Bus_Out together → only o_Mem_WR ever pulses; o_Error = 1 and stays 1 until reset.
- Timeout, with TIMEOUT_MAX = 4: read with i_Mem_Ready held low → o_Error set after 4 wait cycles; o_Done pulses; no o_Data_Valid; o_Data8 unchanged.
- Reset mid-transfer: assert i_Reset in T3 → next cycle state is IDLE, strobes are 0, o_Stall is 0, no o_Done; a following read completes normally.

Source files
------------

// File: rtl/bus_interface_unit_pkg.sv
// Shared CPU package: bus widths, memory-cycle state encoding and T-state count.
package bus_interface_unit_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned WAIT_W   = 8;
  localparam int unsigned T_STATES = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4
  } biu_state_e;

endpackage

// File: rtl/bus_interface_unit_if.sv
// Bus bundle between the CPU/memory environment and the bus interface unit.
interface bus_interface_unit_if;
  import bus_interface_unit_pkg::*;

  // CPU side
  logic              i_Address_Out;
  logic              i_Bus_In;
  logic              i_Bus_Out;
  logic [ADDR_W-1:0] i_Addr16;
  logic [DATA_W-1:0] i_Data8;
  logic [DATA_W-1:0] o_Data8;
  logic              o_Data_Valid;
  logic              o_Done;
  logic              o_Stall;
  logic              o_Error;
  // Memory side
  logic [ADDR_W-1:0] o_Mem_Addr;
  logic              o_Mem_RD;
  logic              o_Mem_WR;
  logic [DATA_W-1:0] o_Mem_Data_Out;
  logic [DATA_W-1:0] i_Mem_Data_In;
  logic              i_Mem_Ready;

  // Bus interface unit view
  modport slave (
    input  i_Address_Out, i_Bus_In, i_Bus_Out, i_Addr16, i_Data8,
    output o_Data8, o_Data_Valid, o_Done, o_Stall, o_Error,
    output o_Mem_Addr, o_Mem_RD, o_Mem_WR, o_Mem_Data_Out,
    input  i_Mem_Data_In, i_Mem_Ready
  );

  // Environment view (control unit plus memory)
  modport master (
    output i_Address_Out, i_Bus_In, i_Bus_Out, i_Addr16, i_Data8,
    input  o_Data8, o_Data_Valid, o_Done, o_Stall, o_Error,
    input  o_Mem_Addr, o_Mem_RD, o_Mem_WR, o_Mem_Data_Out,
    output i_Mem_Data_In, i_Mem_Ready
  );

endinterface

// File: rtl/bus_interface_unit_wait_timer.sv
// Saturating wait-state counter with clear, enable and terminal-count flag.
module bus_interface_unit_wait_timer
  import bus_interface_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_MAX = 255
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Terminal
);

  localparam logic [WAIT_W-1:0] TC_VALUE = WAIT_W'(TIMEOUT_MAX);

  logic [WAIT_W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise increment without wrapping.
  always_comb begin
    count_d = count_q;
    if (i_Clear) begin
      count_d = '0;
    end else if (i_Enable && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Terminal count is flagged in the same cycle the counter reaches the limit.
  assign o_Terminal = i_Enable && (count_d == TC_VALUE);

  // Counter register.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/bus_interface_unit.sv
// Bus interface unit: MAR, four-state external memory cycle with wait states,
// read-data return, stall and sticky error reporting.
module bus_interface_unit
  import bus_interface_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_MAX = 255
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  bus_interface_unit_if.slave   bus
);

  biu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data8_q, data8_d;
  logic              is_write_q, is_write_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              request;
  logic              wt_clear;
  logic              wt_enable;
  logic              wt_terminal;

  assign request   = bus.i_Bus_In || bus.i_Bus_Out;
  assign wt_clear  = (state_q == ST_IDLE);
  assign wt_enable = (state_q == ST_T3) && !bus.i_Mem_Ready;

  bus_interface_unit_wait_timer #(
    .TIMEOUT_MAX (TIMEOUT_MAX)
  ) u_wait_timer (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_Clear    (wt_clear),
    .i_Enable   (wt_enable),
    .o_Terminal (wt_terminal)
  );

  // Next-state and registered-output logic for the memory cycle.
  // Strobes are computed from the upcoming state so the flops present them
  // exactly during T2..T3 without combinational decode on the outputs.
  always_comb begin
    state_d    = state_q;
    mar_d      = mar_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data8_d    = data8_q;
    is_write_d = is_write_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    error_d    = error_q;

    if (bus.i_Address_Out) begin
      mar_d = bus.i_Addr16;
    end

    case (state_q)
      ST_IDLE: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        if (request) begin
          state_d    = ST_T1;
          is_write_d = bus.i_Bus_Out;
          addr_d     = bus.i_Address_Out ? bus.i_Addr16 : mar_q;
          if (bus.i_Bus_Out) begin
            wdata_d = bus.i_Data8;
          end
          if (bus.i_Bus_In && bus.i_Bus_Out) begin
            error_d = 1'b1;
          end
        end
      end
      ST_T1: begin
        state_d = ST_T2;
        rd_d    = !is_write_q;
        wr_d    = is_write_q;
      end
      ST_T2: begin
        state_d = ST_T3;
      end
      ST_T3: begin
        if (bus.i_Mem_Ready) begin
          state_d = ST_T4;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = 1'b1;
          if (!is_write_q) begin
            data8_d = bus.i_Mem_Data_In;
            valid_d = 1'b1;
          end
        end else if (wt_terminal) begin
          state_d = ST_T4;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = 1'b1;
          error_d = 1'b1;
        end
      end
      ST_T4: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      mar_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data8_q    <= '0;
      is_write_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data8_q    <= data8_d;
      is_write_q <= is_write_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Stall is combinational so a request is frozen in the very cycle it is seen.
  always_comb begin
    bus.o_Stall = 1'b0;
    case (state_q)
      ST_IDLE:             bus.o_Stall = request;
      ST_T1, ST_T2, ST_T3: bus.o_Stall = 1'b1;
      default:             bus.o_Stall = 1'b0;
    endcase
  end

  assign bus.o_Data8        = data8_q;
  assign bus.o_Data_Valid   = valid_q;
  assign bus.o_Done         = done_q;
  assign bus.o_Error        = error_q;
  assign bus.o_Mem_Addr     = addr_q;
  assign bus.o_Mem_RD       = rd_q;
  assign bus.o_Mem_WR       = wr_q;
  assign bus.o_Mem_Data_Out = wdata_q;

endmodule

// File: tb/tb_bus_interface_unit.sv
// Self-checking bench for bus_interface_unit against a transaction-level model.
module tb_bus_interface_unit;
  import bus_interface_unit_pkg::*;

  localparam int unsigned TO = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Transaction-level model state
  logic [15:0] mar_m;
  logic [7:0]  data8_m;
  bit          err_m;

  bus_interface_unit_if bus ();

  bus_interface_unit #(.TIMEOUT_MAX(TO)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_Address_Out = 1'b0;
    bus.i_Bus_In      = 1'b0;
    bus.i_Bus_Out     = 1'b0;
    bus.i_Addr16      = '0;
    bus.i_Data8       = '0;
    bus.i_Mem_Data_In = '0;
    bus.i_Mem_Ready   = 1'b1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mar_m = '0; data8_m = '0; err_m = 1'b0;
    @(negedge clk);
    check("rst_error", 32'(bus.o_Error), 32'd0);
  endtask

  task automatic load_mar(input logic [15:0] a);
    @(posedge clk); #1;
    idle_inputs();
    bus.i_Address_Out = 1'b1;
    bus.i_Addr16      = a;
    mar_m = a;
  endtask

  // One complete transfer: request in cycle 0, memory holds ready low for
  // w cycles starting at the first T3 cycle (cycle 3).
  task automatic xfer(input bit aout, input logic [15:0] a, input bit rin, input bit wout,
                      input logic [7:0] wd, input int w, input logic [7:0] md,
                      input bit mar_busy, input logic [15:0] a2);
    logic [15:0] exp_addr;
    bit is_wr, to, done_seen, valid_at_done, rdy;
    int t3n, exp_done, done_k, rd_cnt, wr_cnt, both, addr_bad, dout_bad, valid_extra, stall_bad;
    exp_addr = aout ? a : mar_m;
    if (aout) mar_m = a;
    is_wr = wout;
    to = (w >= int'(TO));
    t3n = to ? int'(TO) : w + 1;
    exp_done = int'(T_STATES) - 1 + t3n;
    if (rin && wout) err_m = 1'b1;
    if (to) err_m = 1'b1;
    if (!is_wr && !to) data8_m = md;
    done_seen = 1'b0; valid_at_done = 1'b0; done_k = -1;
    rd_cnt = 0; wr_cnt = 0; both = 0; addr_bad = 0; dout_bad = 0; valid_extra = 0; stall_bad = 0;
    for (int k = 0; k <= exp_done + 4 && !done_seen; k++) begin
      @(posedge clk); #1;
      bus.i_Bus_In      = (k == 0) ? rin : 1'b0;
      bus.i_Bus_Out     = (k == 0) ? wout : 1'b0;
      bus.i_Address_Out = (k == 0) ? aout : ((k == 2) && mar_busy);
      bus.i_Addr16      = (k == 0) ? a : ((k == 2) ? a2 : 16'($urandom));
      bus.i_Data8       = (k == 0) ? wd : 8'($urandom);
      rdy = !(k >= 3 && k < 3 + w);
      bus.i_Mem_Ready   = rdy;
      bus.i_Mem_Data_In = rdy ? md : ~md;
      @(negedge clk);
      if (k == 0) begin
        check("stall_on_request", 32'(bus.o_Stall), 32'd1);
      end else begin
        if (bus.o_Mem_RD) rd_cnt++;
        if (bus.o_Mem_WR) wr_cnt++;
        if (bus.o_Mem_RD && bus.o_Mem_WR) both++;
        if (bus.o_Mem_Addr !== exp_addr) addr_bad++;
        if (is_wr && bus.o_Mem_Data_Out !== wd) dout_bad++;
        if (bus.o_Done) begin
          done_seen = 1'b1;
          done_k = k;
          valid_at_done = bus.o_Data_Valid;
          if (bus.o_Stall !== 1'b0) stall_bad++;
        end else begin
          if (bus.o_Data_Valid) valid_extra++;
          if (bus.o_Stall !== 1'b1) stall_bad++;
        end
      end
    end
    if (mar_busy) mar_m = a2;
    check("done_seen", 32'(done_seen), 32'd1);
    check("done_cycle", 32'(done_k), 32'(exp_done));
    check("rd_cycles", 32'(rd_cnt), is_wr ? 32'd0 : 32'(t3n + 1));
    check("wr_cycles", 32'(wr_cnt), is_wr ? 32'(t3n + 1) : 32'd0);
    check("strobes_onehot", 32'(both), 32'd0);
    check("addr_stable", 32'(addr_bad), 32'd0);
    check("wdata_stable", 32'(dout_bad), 32'd0);
    check("stall_profile", 32'(stall_bad), 32'd0);
    check("valid_at_done", 32'(valid_at_done), 32'(!is_wr && !to));
    check("valid_spurious", 32'(valid_extra), 32'd0);
    check("data8", 32'(bus.o_Data8), 32'(data8_m));
    check("error", 32'(bus.o_Error), 32'(err_m));
    if (bus.o_Done) check("last_addr", 32'(bus.o_Mem_Addr), 32'(exp_addr));
  endtask

  initial begin
    logic [15:0] ra, ra2;
    int r;
    checks = 0; errors = 0;
    mar_m = '0; data8_m = '0; err_m = 1'b0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_data8", 32'(bus.o_Data8), 32'd0);
    check("reset_addr", 32'(bus.o_Mem_Addr), 32'd0);
    check("reset_dout", 32'(bus.o_Mem_Data_Out), 32'd0);
    check("reset_rd", 32'(bus.o_Mem_RD), 32'd0);
    check("reset_wr", 32'(bus.o_Mem_WR), 32'd0);
    check("reset_valid", 32'(bus.o_Data_Valid), 32'd0);
    check("reset_done", 32'(bus.o_Done), 32'd0);
    check("reset_stall", 32'(bus.o_Stall), 32'd0);
    check("reset_error", 32'(bus.o_Error), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Same-cycle bypass with MAR still zero
    xfer(1'b1, 16'h1234, 1'b1, 1'b0, 8'h00, 0, 8'h3C, 1'b0, 16'h0);
    // Read, zero waits
    load_mar(16'hC000);
    xfer(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 0, 8'h5A, 1'b0, 16'h0);
    // Write, 3 wait states, with a MAR load while busy
    load_mar(16'hFF80);
    xfer(1'b0, 16'h0000, 1'b0, 1'b1, 8'hA5, 3, 8'h00, 1'b1, 16'h4242);
    // Next read picks up the MAR loaded during the write
    xfer(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1, 8'h81, 1'b0, 16'h0);
    // Conflict: write wins, error sticks
    xfer(1'b0, 16'h0000, 1'b1, 1'b1, 8'h69, 0, 8'h00, 1'b0, 16'h0);
    xfer(1'b1, 16'h0F0F, 1'b1, 1'b0, 8'h00, 2, 8'hC3, 1'b0, 16'h0);

    // Reset asserted in T3
    @(posedge clk); #1;
    idle_inputs();
    bus.i_Bus_In = 1'b1; bus.i_Address_Out = 1'b1; bus.i_Addr16 = 16'hBEEF;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.i_Mem_Ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rd_in_t3", 32'(bus.o_Mem_RD), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_Mem_Ready = 1'b1;
    mar_m = '0; data8_m = '0; err_m = 1'b0;
    @(negedge clk);
    check("midrst_rd", 32'(bus.o_Mem_RD), 32'd0);
    check("midrst_wr", 32'(bus.o_Mem_WR), 32'd0);
    check("midrst_stall", 32'(bus.o_Stall), 32'd0);
    check("midrst_error", 32'(bus.o_Error), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_done", 32'(bus.o_Done), 32'd0);
      @(negedge clk);
    end
    // Following read completes normally
    xfer(1'b1, 16'h7777, 1'b1, 1'b0, 8'h00, 0, 8'h99, 1'b0, 16'h0);
    // Timeout on a read: data unchanged, error set
    xfer(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, int'(TO), 8'hEE, 1'b0, 16'h0);
    apply_reset();

    // Randomized transfers
    for (int i = 0; i < 40; i++) begin
      r   = int'($urandom_range(0, 9));
      ra  = 16'($urandom);
      ra2 = 16'($urandom);
      xfer(1'($urandom), ra, (r < 4) || (r >= 8), r >= 4, 8'($urandom),
           int'($urandom_range(0, 6)), 8'($urandom), 1'($urandom), ra2);
      if (i % 10 == 9) apply_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
